// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited request issue, in-flight PC tracking and a
// small instruction queue toward decode. Define FETCH_PERF_CNT_EN to add stall/flush counters.
module fetch_queue #(
    parameter int              size     = 32,
    parameter logic [size-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [size-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [size-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [size-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [size-1:0] inst_data,
    output logic [size-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = 16;

    logic [size-1:0] fetch_pc;
    logic [size-1:0] f_pc [DEPTH];
    logic [size-1:0] q_pc [DEPTH];
    logic [size-1:0] q_data [DEPTH];
    logic [PW-1:0]   f_wr, f_rd, f_count;
    logic [PW-1:0]   q_wr, q_rd, q_count;
    logic [DW-1:0]   drop_cnt;
    logic [PW:0]     credits;
    logic            deq, req_fire, rsp_live, rsp_drop, rsp_any;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign f_count    = f_wr - f_rd;
    assign q_count    = q_wr - q_rd;
    assign inst_valid = (q_count != '0);
    assign inst_data  = inst_valid ? q_data[q_rd[AW-1:0]] : '0;
    assign inst_pc    = inst_valid ? q_pc[q_rd[AW-1:0]] : '0;
    assign imem_addr  = fetch_pc;

    // A same-cycle dequeue frees its slot early so a single-cycle memory can stream at full rate
    assign deq            = inst_valid && inst_ready && !redirect_valid;
    assign credits        = {1'b0, q_count} + {1'b0, f_count} - {{PW{1'b0}}, deq};
    assign imem_req_valid = !reset && !redirect_valid && (credits < (PW+1)'(DEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_live = imem_rsp_valid && (drop_cnt == '0) && (f_count != '0) && !redirect_valid;
    assign rsp_any  = imem_rsp_valid && ((drop_cnt != '0) || (f_count != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            f_wr     <= '0;
            f_rd     <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight becomes stale; the redirect-cycle response is already gone
            fetch_pc <= {redirect_pc[size-1:2], 2'b00};
            f_wr     <= '0;
            f_rd     <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            drop_cnt <= drop_cnt + DW'(f_count) - DW'(rsp_any);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + size'(4);
                f_wr     <= f_wr + PW'(1);
            end
            if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
            if (rsp_live) begin
                f_rd <= f_rd + PW'(1);
                q_wr <= q_wr + PW'(1);
            end
            if (deq) q_rd <= q_rd + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) f_pc[f_wr[AW-1:0]] <= fetch_pc;
        if (rsp_live) begin
            q_pc[q_wr[AW-1:0]]   <= f_pc[f_rd[AW-1:0]];
            q_data[q_wr[AW-1:0]] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!inst_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
            if (redirect_valid && (flush_count != '1)) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a behavioural in-order instruction memory.
// Instruction word returned for address A is A ^ 32'hDEAD_0000.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int checks = 0;
    int passed = 0;
    bit rsp_en = 1'b0;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    fetch_queue #(.size(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    // Memory: accepted requests queue up, one response per cycle when rsp_en, earliest next cycle
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) mq.delete();
            else if (imem_req_valid && imem_req_ready) mq.push_back(imem_addr);
            @(posedge clk);
            #1;
            if (!reset && rsp_en && mq.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mq.pop_front() ^ 32'hDEAD_0000;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        rsp_en = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", imem_req_valid); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %b want 0", inst_valid); else passed++;
        checks++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) $display("FAIL rst_inst got data %h pc %h want 0 0", inst_data, inst_pc); else passed++;
        checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h want 00000000", imem_addr); else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_pc [3]   = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_dat [3]  = '{32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_0008};
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        rsp_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr[i])
                    $display("FAIL stream_req%0d got v=%b addr %h want v=1 addr %h", i, imem_req_valid, imem_addr, exp_addr[i]);
                else passed++;
            end
            if (i < 2) begin
                checks++; if (inst_valid !== 1'b0) $display("FAIL stream_early%0d got inst_valid %b want 0", i, inst_valid); else passed++;
            end else begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i-2] || inst_data !== exp_dat[i-2])
                    $display("FAIL stream_inst%0d got v=%b pc %h data %h want v=1 pc %h data %h", i, inst_valid, inst_pc, inst_data, exp_pc[i-2], exp_dat[i-2]);
                else passed++;
            end
            cyc();
        end
    endtask

    task automatic test_decode_stall();
        int  nreq = 0;
        bit  moved = 1'b0;
        logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        rsp_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) nreq++;
            if (i >= 2 && (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'hDEAD_0000)) moved = 1'b1;
            if (i < 9) cyc();
        end
        checks++; if (nreq != 2) $display("FAIL stall_req_count got %0d want 2", nreq); else passed++;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid got %b want 0", imem_req_valid); else passed++;
        checks++; if (moved) $display("FAIL stall_head_stable got changed want stable pc 00000000"); else passed++;
        cyc();
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8)
                    $display("FAIL stall_resume_req got v=%b addr %h want v=1 addr 00000008", imem_req_valid, imem_addr);
                else passed++;
            end
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i])
                $display("FAIL stall_order%0d got v=%b pc %h want v=1 pc %h", i, inst_valid, inst_pc, exp_pc[i]);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        rsp_en = 1'b0;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL redir_suppress got %b want 0", imem_req_valid); else passed++;
        cyc();
        redirect_valid = 1'b0;
        rsp_en = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL redir_addr got v=%b addr %h want v=1 addr 00000100", imem_req_valid, imem_addr);
        else passed++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL redir_inst_after got %b want 0", inst_valid); else passed++;
        for (int k = 0; k < 10 && !found; k++) begin
            cyc();
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        checks++;
        if (!found || inst_pc !== 32'h100 || inst_data !== 32'hDEAD_0100)
            $display("FAIL redir_first_inst got found=%b pc %h data %h want pc 00000100 data dead0100", found, inst_pc, inst_data);
        else passed++;
    endtask

    task automatic test_req_stall();
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] prev = '0;
`endif
        do_reset();
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        rsp_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1 || inst_valid !== 1'b0)
                $display("FAIL memstall%0d got addr %h v=%b inst_valid %b want addr 00000000 v=1 inst_valid 0", i, imem_addr, imem_req_valid, inst_valid);
            else passed++;
`ifdef FETCH_PERF_CNT_EN
            if (i > 0) begin
                checks++;
                if (stall_cycles !== prev + 32'd1) $display("FAIL stall_cnt%0d got %0d want %0d", i, stall_cycles, prev + 32'd1);
                else passed++;
            end
            prev = stall_cycles;
`endif
            cyc();
        end
    endtask

    task automatic test_back_to_back_redirect();
        bit found = 1'b0;
        bit bad = 1'b0;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        rsp_en = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL b2b_suppress1 got %b want 0", imem_req_valid); else passed++;
        cyc();
        redirect_pc = 32'h300;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL b2b_suppress2 got req %b inst %b want 0 0", imem_req_valid, inst_valid);
        else passed++;
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h300)
            $display("FAIL b2b_addr got v=%b addr %h want v=1 addr 00000300", imem_req_valid, imem_addr);
        else passed++;
        for (int k = 0; k < 10 && !found; k++) begin
            cyc();
            @(negedge clk);
            if (inst_valid) begin
                found = 1'b1;
                if (inst_pc !== 32'h300) bad = 1'b1;
            end
        end
        checks++;
        if (!found || bad) $display("FAIL b2b_first_inst got found=%b pc %h want pc 00000300", found, inst_pc);
        else passed++;
`ifdef FETCH_PERF_CNT_EN
        checks++; if (flush_count !== 32'd2) $display("FAIL b2b_flush_count got %0d want 2", flush_count); else passed++;
`endif
    endtask

    task automatic test_reset_midstream();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        rsp_en = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0)
            $display("FAIL mid_full got inst %b req %b want 1 0", inst_valid, imem_req_valid);
        else passed++;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0 || imem_req_valid !== 1'b0)
            $display("FAIL mid_async got inst %b data %h pc %h req %b want all 0", inst_valid, inst_data, inst_pc, imem_req_valid);
        else passed++;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0)
            $display("FAIL mid_restart got v=%b addr %h inst %b want v=1 addr 00000000 inst 0", imem_req_valid, imem_addr, inst_valid);
        else passed++;
        cyc();
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h4) $display("FAIL mid_next_addr got %h want 00000004", imem_addr); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        test_reset();
        test_stream();
        test_decode_stall();
        test_redirect();
        test_req_stall();
        test_back_to_back_redirect();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter: size, 32, data/address width.
REQ-002 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter: DEPTH, 2, instruction queue entries (power of two, >=2).
REQ-004 SHALL implement the already-decided clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have port: imem_req_valid  out  1  fetch request to instruction memory.
REQ-008 SHALL have port: imem_req_ready  in  1  memory accepts request this cycle.
REQ-009 SHALL have port: imem_addr  out  size  word-aligned fetch address.
REQ-010 SHALL have port: imem_rsp_valid  in  1  response data valid; responses are in order.
REQ-011 SHALL have port: imem_rsp_data  in  size  fetched instruction word.
REQ-012 SHALL have port: redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-013 SHALL have port: redirect_pc  in  size  new fetch target.
REQ-014 SHALL have port: inst_valid  out  1  instruction offered to decoder.
REQ-015 SHALL have port: inst_ready  in  1  decoder accepts (low = stall).
REQ-016 SHALL have port: inst_data  out  size  instruction word to decoder.
REQ-017 SHALL have port: inst_pc  out  size  PC of inst_data.

Function
REQ-018 SHALL hold fetch PC register; imem_addr = fetch PC.
REQ-019 SHALL track credits = queue occupancy + outstanding requests; imem_req_valid = (credits < DEPTH) and not redirect_valid.
REQ-020 SHALL, on request handshake (valid & ready), advance fetch PC by 4 (mod 2^size) and push fetch PC into in-flight PC FIFO (DEPTH entries).
REQ-021 SHALL, on imem_rsp_valid, pop in-flight PC FIFO and enqueue {PC, data} into instruction queue; 1-cycle minimum latency response to inst_valid.
REQ-022 SHALL drive inst_valid = queue not empty; inst_data/inst_pc = queue head, stable while inst_valid & !inst_ready.
REQ-023 SHALL dequeue on inst_valid & inst_ready; enqueue and dequeue in same cycle are both honoured, occupancy unchanged.
REQ-024 SHALL never overflow: credit rule guarantees space; response with no outstanding request is ignored.
REQ-025 SHALL, on redirect_valid: empty instruction queue and in-flight FIFO, set fetch PC = {redirect_pc[size-1:2], 2'b00}, record outstanding count as drop count, suppress request this cycle.
REQ-026 SHALL discard responses while drop count > 0 (decrement per response), including a response arriving in the redirect cycle; dropped responses do not free credits beyond those recorded.
REQ-027 SHALL drive inst_valid = 0 in the cycle after redirect; first post-redirect request issues the cycle after redirect.
REQ-028 SHALL treat redirect with simultaneous inst_ready as flush-priority: dequeue has no effect.
REQ-029 SHALL treat back-to-back redirects: later redirect_pc wins; drop count re-computed from current outstanding plus remaining drops.

Reset
REQ-030 SHALL on reset: fetch PC = RESET_PC, queues empty, credits/drop count = 0, imem_req_valid = 0, inst_valid = 0, inst_data/inst_pc = 0.
REQ-031 SHALL issue first request the first cycle after reset deasserts; reset mid-operation discards all state including outstanding responses.

Configuration
REQ-032 SHALL, with FETCH_PERF_CNT_EN defined, add outputs stall_cycles (32) counting cycles inst_valid=0 outside reset, and flush_count (32) counting redirects; both saturate at all-ones, reset to 0.
REQ-033 SHALL, without FETCH_PERF_CNT_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-034 SHALL cover: reset release, imem_req_ready=1, 1-cycle responses, inst_ready=1 -> addresses 0x0,0x4,0x8 in consecutive cycles; inst_pc matches, one instruction per cycle.
REQ-035 SHALL cover: inst_ready=0 for 10 cycles -> exactly DEPTH (2) requests issued, imem_req_valid=0 thereafter, head stable; release -> order preserved.
REQ-036 SHALL cover: redirect_valid with redirect_pc=0x103 while 2 requests outstanding -> both responses dropped, next imem_addr=0x100, first inst_pc=0x100.
REQ-037 SHALL cover: imem_req_ready=0 for 5 cycles -> imem_addr held at 0x0, inst_valid=0; with FETCH_PERF_CNT_EN stall_cycles increments each cycle.
REQ-038 SHALL cover: redirect on two consecutive cycles (0x200 then 0x300) -> no instruction from 0x200 delivered; first inst_pc=0x300; flush_count=2.
REQ-039 SHALL cover: reset asserted mid-stream with queue full -> outputs zero asynchronously; after release fetch restarts at RESET_PC.
